// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: word width, default
// geometry/latency, FSM state encoding and an address-width helper.
package mem_pkg;

  localparam int WORD_W          = 32;
  localparam int DEFAULT_DEPTH   = 256;
  localparam int DEFAULT_LATENCY = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Word-index width for a given depth, never less than one bit.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between an initiator and the data-memory responder.
interface dmem_responder_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read, no reset so
// it maps onto block RAM and keeps its contents across responder resets.
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = addr_bits(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_reg[addr] <= wdata;
      end else begin
        rdata <= mem_reg[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request at a time, waits
// LATENCY cycles, performs the access and strobes a one-cycle response.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int               AW      = addr_bits(DEPTH);
  localparam logic [30:0]      DEPTH_W = 31'(DEPTH);
  localparam logic [CNT_W-1:0] LAT_W   = CNT_W'(LATENCY);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              we_reg;
  logic [29:0]       idx_reg;
  logic              misalign_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic [WORD_W-1:0] hold_reg;
  logic [WORD_W-1:0] arr_rdata;
  logic [WORD_W-1:0] resp_word;
  logic              accept;
  logic              access;
  logic              fault;

  assign accept = (state_reg == IDLE) && bus.req_valid;
  assign access = (state_reg == WAIT) && (cnt_reg == '0);
  assign fault  = misalign_reg || ({1'b0, idx_reg} >= DEPTH_W);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          state_next = WAIT;
          cnt_next   = LAT_W;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Request fields stay latched through RESP so the fault decode and the
  // write echo remain valid while the response is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg       <= 1'b0;
      idx_reg      <= '0;
      misalign_reg <= 1'b0;
      wdata_reg    <= '0;
      hold_reg     <= '0;
    end else begin
      if (accept) begin
        we_reg       <= bus.req_we;
        idx_reg      <= bus.req_addr[31:2];
        misalign_reg <= |bus.req_addr[1:0];
        wdata_reg    <= bus.req_wdata;
      end
      if (state_reg == RESP) begin
        hold_reg <= resp_word;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (access && !fault),
    .we    (we_reg),
    .addr  (idx_reg[AW-1:0]),
    .wdata (wdata_reg),
    .rdata (arr_rdata)
  );

  assign resp_word = fault ? '0 : (we_reg ? wdata_reg : arr_rdata);

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_err   = (state_reg == RESP) && fault;
  assign bus.resp_rdata = (state_reg == RESP) ? resp_word : hold_reg;

endmodule
